// File: rtl/change_dispense_arbiter.sv
// Fixed-priority arbiter sharing one coin-change dispenser among three requesters.
// Optional dispense watchdog enabled by defining CHG_ARB_TIMEOUT_EN.
module change_dispense_arbiter #(
    parameter int MAX_CHANGE     = 995,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [9:0] amt0,
    input  logic [9:0] amt1,
    input  logic [9:0] amt2,
    output logic [2:0] ack,
    output logic [2:0] err,
    output logic       active,
    output logic [1:0] grant_id,
    output logic       disp,
    output logic [9:0] disp_change,
    input  logic       disp_busy,
    input  logic       disp_done,
    output logic       fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DISP  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    logic [2:0] state, nxt;
    logic [1:0] id, id_nxt;
    logic [9:0] latch, latch_nxt;
    logic [2:0] armed;
    logic [2:0] elig;
    logic [2:0] id_oh;
    logic [9:0] amt_sel;
    logic       bad_amt;
    logic       tmo;

    assign elig  = req & armed;
    assign id_oh = 3'b001 << id_nxt;

    // Select the amount of the granted requester.
    always_comb begin
        case (id)
            2'd0:    amt_sel = amt0;
            2'd1:    amt_sel = amt1;
            default: amt_sel = amt2;
        endcase
    end

    assign bad_amt = (amt_sel % 10'd5 != 10'd0) ||
                     (amt_sel > 10'(MAX_CHANGE));

`ifdef CHG_ARB_TIMEOUT_EN
    logic [12:0] cnt;

    assign tmo = (state == S_DISP) && !disp_done &&
                 (cnt == 13'(TIMEOUT_CYCLES - 1));

    // Watchdog counter runs only in DISP; fault stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            if (state != S_DISP) cnt <= '0;
            else                 cnt <= cnt + 13'd1;
            if (state == S_DISP && nxt == S_FAULT) fault <= 1'b1;
        end
    end
`else
    assign tmo   = 1'b0;
    assign fault = 1'b0;
`endif

    // Next-state decode; LOAD samples the requester amount exactly once.
    always_comb begin
        nxt       = state;
        id_nxt    = id;
        latch_nxt = latch;
        case (state)
            S_IDLE: begin
                if (!disp_busy && !fault && elig != 3'b000) begin
                    nxt = S_LOAD;
                    if (elig[0])      id_nxt = 2'd0;
                    else if (elig[1]) id_nxt = 2'd1;
                    else              id_nxt = 2'd2;
                end
            end
            S_LOAD: begin
                latch_nxt = amt_sel;
                if (amt_sel == 10'd0) nxt = S_ACK;
                else if (bad_amt)     nxt = S_ERR;
                else                  nxt = S_DISP;
            end
            S_DISP: begin
                if (disp_done) nxt = S_ACK;
                else if (tmo)  nxt = S_FAULT;
            end
            S_ACK:   nxt = S_GAP;
            S_ERR:   nxt = S_GAP;
            S_GAP:   nxt = S_IDLE;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            id          <= 2'd0;
            latch       <= '0;
            armed       <= 3'b111;
            ack         <= '0;
            err         <= '0;
            active      <= 1'b0;
            grant_id    <= 2'd3;
            disp        <= 1'b0;
            disp_change <= '0;
        end else begin
            state       <= nxt;
            id          <= id_nxt;
            latch       <= latch_nxt;
            armed       <= (armed & ~(ack | err)) | ~req;
            ack         <= (nxt == S_ACK) ? id_oh : 3'b000;
            err         <= (nxt == S_ERR ||
                            (state == S_DISP && nxt == S_FAULT)) ?
                           id_oh : 3'b000;
            active      <= (nxt != S_IDLE);
            grant_id    <= (nxt == S_IDLE) ? 2'd3 : id_nxt;
            disp        <= (nxt == S_DISP);
            disp_change <= (nxt == S_DISP) ? latch_nxt : 10'd0;
        end
    end

endmodule

// File: tb/tb_change_dispense_arbiter.sv
// Scoreboard bench for change_dispense_arbiter.
// Directed vectors; a negedge monitor checks every ack/err against a queue.
module tb_change_dispense_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [9:0] amt0 = '0, amt1 = '0, amt2 = '0;
    logic [2:0] ack, err;
    logic       active, disp, fault;
    logic [1:0] grant_id;
    logic [9:0] disp_change;
    logic       disp_busy = 1'b0;
    logic       disp_done = 1'b0;

    typedef struct {
        logic [2:0] ack;
        logic [2:0] err;
        bit         disp;
        int         amt;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nbad = 0;

    always #5 clk = ~clk;

    change_dispense_arbiter #(
        .MAX_CHANGE(995),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .amt0(amt0), .amt1(amt1), .amt2(amt2),
        .ack(ack), .err(err), .active(active),
        .grant_id(grant_id), .disp(disp),
        .disp_change(disp_change),
        .disp_busy(disp_busy), .disp_done(disp_done),
        .fault(fault)
    );

    task automatic chk(string name, int act, int expv);
        nvec++;
        if (act != expv) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, expv, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(logic [2:0] a, logic [2:0] e, bit d, int amt);
        exp_t x;
        x.ack = a; x.err = e; x.disp = d; x.amt = amt;
        q.push_back(x);
    endtask

    task automatic wait_disp(string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (disp) begin ok = 1; break; end
            tick(1);
        end
        chk({name, "_disp_seen"}, int'(ok), 1);
    endtask

    task automatic wait_done(string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if ((ack | err) != 3'b000) begin ok = 1; break; end
            tick(1);
        end
        chk({name, "_done_seen"}, int'(ok), 1);
    endtask

    task automatic pulse_done();
        disp_done = 1'b1;
        tick(1);
        disp_done = 1'b0;
    endtask

    // Monitor: disp stability, idle gap, and scoreboard pops on ack/err.
    bit seen, had_disp, prev_disp;
    int seen_amt, low_cnt;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 0; had_disp = 0; prev_disp = 0; low_cnt = 0;
        end else begin
            if (disp) begin
                if (!prev_disp) begin
                    if (had_disp) chk("idle_gap_ge2", int'(low_cnt >= 2), 1);
                    seen = 1; had_disp = 1; seen_amt = int'(disp_change);
                end else begin
                    chk("disp_change_stable", int'(disp_change), seen_amt);
                end
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            if ((ack | err) != 3'b000) begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", int'({ack, err}), 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_ack", int'(ack), int'(e.ack));
                    chk("sb_err", int'(err), int'(e.err));
                    chk("sb_disp_rose", int'(seen), int'(e.disp));
                    if (e.disp) chk("sb_amount", seen_amt, e.amt);
                end
                seen = 0;
            end
            prev_disp = disp;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        chk("rst_ack", int'(ack), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_grant_id", int'(grant_id), 3);
        chk("rst_disp", int'(disp), 0);
        chk("rst_disp_change", int'(disp_change), 0);
        chk("rst_fault", int'(fault), 0);
        rst_n = 1'b1;
        tick(2);

        // Single vend with latency checks.
        amt1 = 10'd35; req = 3'b010;
        push(3'b010, 3'b000, 1, 35);
        tick(1);
        chk("t1_load_active", int'(active), 1);
        chk("t1_load_disp", int'(disp), 0);
        chk("t1_load_grant", int'(grant_id), 1);
        tick(1);
        chk("t1_disp_rise", int'(disp), 1);
        chk("t1_disp_change", int'(disp_change), 35);
        amt1 = 10'd500;
        tick(5);
        chk("t1_disp_held", int'(disp), 1);
        pulse_done();
        chk("t1_ack", int'(ack), 2);
        chk("t1_disp_low_at_ack", int'(disp), 0);
        chk("t1_change_zero_at_ack", int'(disp_change), 0);
        req = 3'b000;
        tick(1);
        chk("t1_ack_single", int'(ack), 0);
        tick(1);
        chk("t1_grant_idle", int'(grant_id), 3);
        chk("t1_active_idle", int'(active), 0);
        tick(2);

        // Contention: priority order 0,1,2.
        amt0 = 10'd10; amt1 = 10'd20; amt2 = 10'd30;
        push(3'b001, 3'b000, 1, 10);
        push(3'b010, 3'b000, 1, 20);
        push(3'b100, 3'b000, 1, 30);
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_disp("cont");
            tick(3);
            pulse_done();
            req[i] = 1'b0;
        end
        tick(4);

        // Held request is not regranted; drop then reassert re-arms.
        amt0 = 10'd15; req = 3'b001;
        push(3'b001, 3'b000, 1, 15);
        wait_disp("rearm1");
        pulse_done();
        tick(10);
        chk("rearm_no_regrant", int'(active), 0);
        chk("rearm_grant_idle", int'(grant_id), 3);
        req = 3'b000;
        tick(1);
        req = 3'b001;
        push(3'b001, 3'b000, 1, 15);
        wait_disp("rearm2");
        pulse_done();
        req = 3'b000;
        tick(4);

        // Illegal, zero and boundary amounts.
        amt1 = 10'd37; req = 3'b010;
        push(3'b000, 3'b010, 0, 0);
        wait_done("odd");
        req = 3'b000; tick(4);
        amt1 = 10'd0; req = 3'b010;
        push(3'b010, 3'b000, 0, 0);
        wait_done("zero");
        req = 3'b000; tick(4);
        amt1 = 10'd1000; req = 3'b010;
        push(3'b000, 3'b010, 0, 0);
        wait_done("over");
        req = 3'b000; tick(4);
        amt1 = 10'd995; req = 3'b010;
        push(3'b010, 3'b000, 1, 995);
        wait_disp("max");
        pulse_done();
        req = 3'b000; tick(4);

        // disp_busy blocks grants; stray disp_done in IDLE is ignored.
        disp_busy = 1'b1; amt1 = 10'd5; req = 3'b010;
        disp_done = 1'b1;
        tick(3);
        disp_done = 1'b0;
        chk("busy_blocks", int'(active), 0);
        disp_busy = 1'b0;
        push(3'b010, 3'b000, 1, 5);
        wait_disp("busy");
        pulse_done();
        req = 3'b000; tick(4);

        // Reset mid-dispense; held req[2] regranted afterwards.
        amt2 = 10'd25; req = 3'b100;
        wait_disp("rst");
        chk("rst_mid_change", int'(disp_change), 25);
        #1 rst_n = 1'b0;
        #1;
        chk("async_disp", int'(disp), 0);
        chk("async_active", int'(active), 0);
        chk("async_ack", int'(ack), 0);
        chk("async_err", int'(err), 0);
        chk("async_grant", int'(grant_id), 3);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push(3'b100, 3'b000, 1, 25);
        wait_disp("post_rst");
        pulse_done();
        req = 3'b000; tick(4);

`ifdef CHG_ARB_TIMEOUT_EN
        // Watchdog: 16 DISP cycles without done.
        amt1 = 10'd10; req = 3'b010;
        push(3'b000, 3'b010, 1, 10);
        wait_disp("wd");
        tick(15);
        chk("wd_disp_before", int'(disp), 1);
        tick(1);
        chk("wd_disp_off", int'(disp), 0);
        chk("wd_err", int'(err), 2);
        chk("wd_fault", int'(fault), 1);
        req = 3'b000; tick(1);
        amt0 = 10'd5; req = 3'b001;
        tick(8);
        chk("wd_no_grant", int'(disp), 0);
        chk("wd_fault_sticky", int'(fault), 1);
        req = 3'b000;
        rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
        chk("wd_fault_cleared", int'(fault), 0);
`endif

        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
